// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch path: data widths, the reset/flush NOP
// and the fetch FSM state encoding.
package riscv_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StDrop
   } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats capture, capture beats hold, and an
// unstalled cycle without capture empties the slot.
module if_id_reg #(
   parameter int unsigned XLEN      = riscv_pkg::XLEN,
   parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
   input  logic            clk,
   input  logic            res_n,
   input  logic            capture,
   input  logic            flush,
   input  logic            stall,
   input  logic [XLEN-1:0] cap_pc,
   input  logic [31:0]     cap_instr,
   output logic            if_valid,
   output logic [XLEN-1:0] if_pc,
   output logic [31:0]     if_instr
);

   logic            valid_q, valid_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [31:0]     instr_q, instr_d;

   always_comb begin
      valid_d = valid_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      if (flush) begin
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
      end else if (capture) begin
         valid_d = 1'b1;
         pc_d    = cap_pc;
         instr_d = cap_instr;
      end else if (!stall) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         instr_q <= NOP_INSTR;
      end else begin
         valid_q <= valid_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   assign if_valid = valid_q;
   assign if_pc    = pc_q;
   assign if_instr = instr_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: drives the PC register, runs one-outstanding
// req/ack fetches and feeds the IF/ID register, with stall and redirect.
module if_fetch_ctrl import riscv_pkg::*; #(
   parameter int unsigned XLEN      = riscv_pkg::XLEN,
   parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
   input  logic            clk,
   input  logic            res_n,
   input  logic [XLEN-1:0] pc_in,
   output logic            pc_write,
   output logic [XLEN-1:0] pc_next,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            stall,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   output logic            if_valid,
   output logic [XLEN-1:0] if_pc,
   output logic [31:0]     if_instr
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] req_pc_q, req_pc_d;
   logic [XLEN-1:0] fetch_addr;
   logic            slot_free;
   logic            capture;

   assign slot_free  = !if_valid || !stall;
   // In IDLE the request (if any) targets the live PC; otherwise the latched one.
   assign fetch_addr = (state_q == StIdle) ? pc_in : req_pc_q;

   always_comb begin
      state_d   = state_q;
      req_pc_d  = req_pc_q;
      imem_req  = 1'b0;
      imem_addr = fetch_addr;
      capture   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!redirect && slot_free) begin
               imem_req = 1'b1;
               req_pc_d = pc_in;
               if (imem_ack) begin
                  capture = 1'b1;
               end else begin
                  state_d = StBusy;
               end
            end
         end
         StBusy: begin
            imem_req = 1'b1;
            if (redirect) begin
               state_d = imem_ack ? StIdle : StDrop;
            end else if (imem_ack) begin
               capture = 1'b1;
               state_d = StIdle;
            end
         end
         StDrop: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      pc_write = redirect || capture;
      pc_next  = redirect ? redirect_pc : fetch_addr + XLEN'(4);
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state_q  <= StIdle;
         req_pc_q <= '0;
      end else begin
         state_q  <= state_d;
         req_pc_q <= req_pc_d;
      end
   end

   if_id_reg #(
      .XLEN      (XLEN),
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk       (clk),
      .res_n     (res_n),
      .capture   (capture),
      .flush     (redirect),
      .stall     (stall),
      .cap_pc    (fetch_addr),
      .cap_instr (imem_rdata),
      .if_valid  (if_valid),
      .if_pc     (if_pc),
      .if_instr  (if_instr)
   );

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with a flag-level fetch model checked every
// cycle, plus literal expectations at key points of each scenario.
module tb_if_fetch_ctrl;

   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] SALT = 32'hA5A5_0000;

   logic        clk;
   logic        res_n;
   logic [31:0] pc_in;
   logic        pc_write;
   logic [31:0] pc_next;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        ack;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;

   logic [31:0] pc_reg;
   logic        pc_ovr_en;
   logic [31:0] pc_ovr;

   int n_vec;
   int n_miss;

   if_fetch_ctrl dut (
      .clk         (clk),
      .res_n       (res_n),
      .pc_in       (pc_in),
      .pc_write    (pc_write),
      .pc_next     (pc_next),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .stall       (stall),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (ack),
      .imem_rdata  (imem_rdata),
      .if_valid    (if_valid),
      .if_pc       (if_pc),
      .if_instr    (if_instr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Environment: PC register and a memory whose data is a function of the address.
   always @(posedge clk or negedge res_n) begin
      if (!res_n) pc_reg <= '0;
      else if (pc_write) pc_reg <= pc_next;
   end
   assign pc_in      = pc_ovr_en ? pc_ovr : pc_reg;
   assign imem_rdata = imem_addr ^ SALT;

   // Model: one pending fetch (maybe doomed) plus the IF/ID slot contents.
   logic        m_pend, m_drop, m_valid;
   logic [31:0] m_pend_pc, m_vpc, m_instr;
   logic        e_req, e_keep, e_pcw;
   logic [31:0] e_addr, e_pcn;

   always_comb begin
      e_req  = m_pend ? 1'b1 : (!redirect && (!m_valid || !stall));
      e_addr = m_pend ? m_pend_pc : pc_in;
      e_keep = e_req && ack && !redirect && !(m_pend && m_drop);
      e_pcw  = redirect || e_keep;
      e_pcn  = redirect ? redirect_pc : e_addr + 32'd4;
   end

   always @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         m_pend <= 1'b0; m_drop <= 1'b0; m_pend_pc <= '0;
         m_valid <= 1'b0; m_vpc <= '0; m_instr <= NOP;
      end else begin
         if (redirect) begin
            m_valid <= 1'b0; m_instr <= NOP;
         end else if (e_keep) begin
            m_valid <= 1'b1; m_vpc <= e_addr; m_instr <= e_addr ^ SALT;
         end else if (!stall) begin
            m_valid <= 1'b0;
         end
         if (m_pend) begin
            if (ack) m_pend <= 1'b0;
            else if (redirect) m_drop <= 1'b1;
         end else if (e_req && !ack) begin
            m_pend <= 1'b1; m_pend_pc <= e_addr; m_drop <= 1'b0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("m_req", {31'b0, imem_req}, {31'b0, e_req});
      if (e_req) check("m_addr", imem_addr, e_addr);
      check("m_pcw", {31'b0, pc_write}, {31'b0, e_pcw});
      if (e_pcw) check("m_pcn", pc_next, e_pcn);
      check("m_valid", {31'b0, if_valid}, {31'b0, m_valid});
      if (m_valid) check("m_ifpc", if_pc, m_vpc);
      check("m_instr", if_instr, m_instr);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_vec = 0; n_miss = 0;
      res_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      ack = 1'b0; pc_ovr_en = 1'b0; pc_ovr = '0;
      repeat (2) @(posedge clk);
      #1 res_n = 1'b1; ack = 1'b1;
      // Zero-wait stream
      @(negedge clk);
      check("rst_instr", if_instr, NOP);
      check("rst_valid", {31'b0, if_valid}, 32'd0);
      check("c0_req", {31'b0, imem_req}, 32'd1);
      check("c0_addr", imem_addr, 32'h0);
      tick(); @(negedge clk);
      check("c1_addr", imem_addr, 32'h4);
      check("c1_ifpc", if_pc, 32'h0);
      check("c1_instr", if_instr, 32'hA5A5_0000);
      tick(); @(negedge clk);
      check("c2_addr", imem_addr, 32'h8);
      check("c2_ifpc", if_pc, 32'h4);
      check("c2_valid", {31'b0, if_valid}, 32'd1);
      // Stall with a valid instruction at 0x8
      tick(); stall = 1'b1; @(negedge clk);
      check("st_ifpc", if_pc, 32'h8);
      check("st_req", {31'b0, imem_req}, 32'd0);
      check("st_pcw", {31'b0, pc_write}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick(); @(negedge clk);
         check("st_hold_pc", if_pc, 32'h8);
         check("st_hold_req", {31'b0, imem_req}, 32'd0);
      end
      tick(); stall = 1'b0; @(negedge clk);
      check("st_rel_addr", imem_addr, 32'hC);
      // Ack delayed 3 cycles at 0x10
      tick(); ack = 1'b0; @(negedge clk);
      check("dl_ifpc", if_pc, 32'hC);
      check("dl_addr0", imem_addr, 32'h10);
      check("dl_pcw0", {31'b0, pc_write}, 32'd0);
      for (int i = 0; i < 2; i++) begin
         tick(); @(negedge clk);
         check("dl_req", {31'b0, imem_req}, 32'd1);
         check("dl_addr", imem_addr, 32'h10);
         check("dl_pcw", {31'b0, pc_write}, 32'd0);
      end
      tick(); ack = 1'b1; @(negedge clk);
      check("dl_ack_pcw", {31'b0, pc_write}, 32'd1);
      check("dl_ack_pcn", pc_next, 32'h14);
      tick(); @(negedge clk);
      check("dl_valid", {31'b0, if_valid}, 32'd1);
      check("dl_ifpc2", if_pc, 32'h10);
      // Redirect to 0x200 while BUSY at 0x20, ack two cycles later
      tick(); tick();
      tick(); ack = 1'b0; @(negedge clk);
      check("rd_addr", imem_addr, 32'h20);
      tick(); redirect = 1'b1; redirect_pc = 32'h200; @(negedge clk);
      check("rd_pcw", {31'b0, pc_write}, 32'd1);
      check("rd_pcn", pc_next, 32'h200);
      tick(); redirect = 1'b0; @(negedge clk);
      check("rd_drop_addr", imem_addr, 32'h20);
      check("rd_valid", {31'b0, if_valid}, 32'd0);
      tick(); ack = 1'b1; @(negedge clk);
      check("rd_drop_pcw", {31'b0, pc_write}, 32'd0);
      tick(); @(negedge clk);
      check("rd_new_addr", imem_addr, 32'h200);
      // Redirect and stall together with a valid instruction
      tick(); redirect = 1'b1; redirect_pc = 32'h300; stall = 1'b1; @(negedge clk);
      check("rs_ifpc", if_pc, 32'h200);
      check("rs_instr", if_instr, 32'hA5A5_0200);
      check("rs_pcn", pc_next, 32'h300);
      check("rs_req", {31'b0, imem_req}, 32'd0);
      tick(); redirect = 1'b0; stall = 1'b0; @(negedge clk);
      check("rs_valid", {31'b0, if_valid}, 32'd0);
      check("rs_nop", if_instr, NOP);
      // PC wrap
      tick(); pc_ovr_en = 1'b1; pc_ovr = 32'hFFFF_FFFC; @(negedge clk);
      check("wr_ifpc", if_pc, 32'h300);
      check("wr_addr", imem_addr, 32'hFFFF_FFFC);
      check("wr_pcn", pc_next, 32'h0);
      tick(); pc_ovr_en = 1'b0; ack = 1'b0; @(negedge clk);
      check("wr_ifpc2", if_pc, 32'hFFFF_FFFC);
      // Asynchronous reset in the middle of an outstanding request
      tick(); #2 res_n = 1'b0; #1;
      check("ar_valid", {31'b0, if_valid}, 32'd0);
      check("ar_ifpc", if_pc, 32'h0);
      check("ar_instr", if_instr, NOP);
      @(posedge clk); #1 res_n = 1'b1; ack = 1'b0;
      // Redirect while BUSY, second redirect while DROP: latest wins
      tick(); redirect = 1'b1; redirect_pc = 32'h400;
      tick(); redirect_pc = 32'h500; @(negedge clk);
      check("dd_pcn", pc_next, 32'h500);
      check("dd_addr", imem_addr, 32'h0);
      tick(); redirect = 1'b0; ack = 1'b1; @(negedge clk);
      check("dd_pcw", {31'b0, pc_write}, 32'd0);
      tick(); @(negedge clk);
      check("dd_addr2", imem_addr, 32'h500);
      tick(); ack = 1'b0; @(negedge clk);
      check("dd_ifpc", if_pc, 32'h500);
      // Redirect in BUSY with same-cycle ack goes straight back to IDLE
      tick(); redirect = 1'b1; redirect_pc = 32'h600; ack = 1'b1; @(negedge clk);
      check("ba_pcn", pc_next, 32'h600);
      tick(); redirect = 1'b0; @(negedge clk);
      check("ba_addr", imem_addr, 32'h600);
      check("ba_req", {31'b0, imem_req}, 32'd1);
      tick(); @(negedge clk);
      check("ba_ifpc", if_pc, 32'h600);
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Instruction-fetch controller wrapped around the PC register. Each cycle it decides the PC register's next value and write enable, and issues one instruction-memory request at the current PC using a req/ack handshake. It holds the fetched instruction in the IF/ID output register until the decode stage accepts it, and supports decode stall and execute-stage redirect (branch/jump flush).

## Interface
- `XLEN`, default 32: address/data width.
- `NOP_INSTR`, default 32'h0000_0013: value of `if_instr` at reset and after a flush (`addi x0,x0,0`).

- `clk`, input, 1: single clock, rising edge.
- `res_n`, input, 1: reset, asynchronous, active-low.
- `pc_in`, input, XLEN: current PC from the PC register's `out`.
- `pc_write`, output, 1: PC register write enable.
- `pc_next`, output, XLEN: value for the PC register's `in`.
- `redirect`, input, 1: taken branch/jump from EX; flushes fetch.
- `redirect_pc`, input, XLEN: target of the redirect.
- `stall`, input, 1: decode cannot accept `if_*` this cycle.
- `imem_req`, output, 1: instruction-memory request.
- `imem_addr`, output, XLEN: request address.
- `imem_ack`, input, 1: request accepted; `imem_rdata` is valid in the same cycle.
- `imem_rdata`, input, 32: instruction word.
- `if_valid`, output, 1: IF/ID holds a valid instruction.
- `if_pc`, output, XLEN: PC of the held instruction.
- `if_instr`, output, 32: held instruction.

## Operation
- FSM states:
  - IDLE: no request outstanding.
  - BUSY: request outstanding; its result is kept.
  - DROP: request outstanding; its result is discarded.
- Slot free means `!if_valid || !stall`.
- In IDLE:
  - `redirect`: `pc_write`=1, `pc_next`=`redirect_pc`, no request, flush.
  - Otherwise, if the slot is free: `imem_req`=1, `imem_addr`=`pc_in`, latch `req_pc`=`pc_in`.
    - With `imem_ack` in the same cycle: capture, stay IDLE.
    - Without it: go to BUSY.
- In BUSY (`imem_req`=1, `imem_addr`=`req_pc`, both held stable until ack):
  - `redirect`: PC written with `redirect_pc`, flush. With ack in the same cycle go to IDLE (data discarded); otherwise go to DROP.
  - `imem_ack` without `redirect`: capture, go to IDLE.
- In DROP (`imem_req`=1, `imem_addr`=`req_pc`):
  - `imem_ack`: discard data, go to IDLE.
  - `redirect`: rewrite PC; the latest redirect wins; stay in DROP.
- Capture:
  - IF/ID gets `if_valid`=1, `if_pc`=`req_pc`, `if_instr`=`imem_rdata`.
  - `pc_write`=1, `pc_next`=`req_pc`+4, modulo 2^XLEN (32'hFFFF_FFFC wraps to 0).
- Flush: `if_valid`=0, `if_instr`=`NOP_INSTR`.
- IF/ID with no capture and no flush:
  - `stall`=1: hold contents.
  - Otherwise: `if_valid`=0.
- `pc_write`=0 in every case not listed above.
- At most one request is outstanding. The PC advances only on a kept ack.

## Timing
- Reset (asynchronous, `res_n`=0): state=IDLE, `if_valid`=0, `if_pc`=0, `if_instr`=`NOP_INSTR`, `req_pc`=0.
- Request outputs are combinational from state and `pc_in`. In the first cycle after reset release `imem_req`=1 and `imem_addr`=`pc_in`.
- An ack in cycle N makes `if_*` valid from cycle N+1.
- With zero-wait memory (ack in the request cycle) throughput is one instruction per cycle.
- `redirect` has priority over `stall` and over a same-cycle ack.
- After a redirect in cycle N, the first request to `redirect_pc` is issued:
  - in cycle N+1 if the block was in IDLE;
  - in the cycle after the dropped ack otherwise.
- Reset mid-request abandons the request; memory is reset by the same `res_n`.
- `stall` while `if_valid`=0 issues a request anyway, because the slot is free.

## Structure
- Shared package `riscv_pkg`: `XLEN`, `NOP_INSTR`, and the fetch-state encoding (IDLE/BUSY/DROP).
- Natural sub-module: `if_id_reg` (the IF/ID register with capture/hold/flush controls). The FSM and PC-next mux live in the top level.

## Test plan
- Reset, then zero-wait memory returning `imem_rdata`=PC^32'hA5A5_0000:
  - `imem_addr` steps 0, 4, 8.
  - `if_pc`=0, 4, 8 in consecutive cycles, with `if_valid` held at 1.
- Ack delayed 3 cycles at PC 0x10:
  - `imem_req` and `imem_addr`=0x10 are held for 3 cycles.
  - `pc_write` is 0 for those cycles and 1 only in the ack cycle.
  - `if_valid` rises one cycle later.
- `stall`=1 for 4 cycles while `if_pc`=0x8:
  - outputs are frozen and no new request is issued.
  - after release, `if_pc`=0xC follows.
- `redirect` to 0x200 while BUSY at 0x20, ack 2 cycles later:
  - the 0x20 data is discarded and `if_valid`=0.
  - the next request is 0x200, then `if_pc`=0x200.
- `redirect` and `stall` together with `if_valid`=1:
  - `if_valid`=0 and `if_instr`=32'h0000_0013 on the next cycle.
  - `pc_next`=`redirect_pc`.
- `pc_in`=32'hFFFF_FFFC with an ack:
  - `pc_next`=0.
  - assert `res_n` mid-request: all outputs reach their reset values immediately (no clock edge needed).
